// File: rtl/n64_audio_i2s_bridge.sv
// n64_audio_i2s_bridge: N64 AI serial audio to I2S, re-timed on AMCLK_i (256*fs)
//   AMCLK_i  : audio master clock, sole clock
//   nARST    : asynchronous active-low reset
//   ASCLK_i  : N64 bit clock (async), ASDATA_i: N64 data, ALRCLK_i: N64 word select (1 = left)
//   ASCLK_o  : I2S bit clock (AMCLK_i/4), ASDATA_o: I2S data, ALRCLK_o: I2S word select (0 = left)
module n64_audio_i2s_bridge (
  input  logic AMCLK_i,
  input  logic nARST,
  input  logic ASCLK_i,
  input  logic ASDATA_i,
  input  logic ALRCLK_i,
  output logic ASCLK_o,
  output logic ASDATA_o,
  output logic ALRCLK_o
);
  logic [2:0]  r_sclk, r_lr;
  logic [1:0]  r_sdat;
  logic [4:0]  r_in_cnt;
  logic [15:0] r_shift, r_left_hold;
  logic [31:0] r_pair, r_frame;
  logic [7:0]  r_c;
  logic        r_asclk, r_asdata, r_alrclk;
  logic        w_sclk_rise, w_lr_edge, w_bit;
  logic [15:0] w_word, w_out_word;
  logic [7:0]  w_c_nxt;
  logic [4:0]  w_s;
  logic [3:0]  w_idx;
  assign w_sclk_rise = r_sclk[1] & ~r_sclk[2];
  assign w_lr_edge   = r_lr[1] ^ r_lr[2];
  assign w_word      = {r_shift[14:0], r_sdat[1]};
  // Outputs are registered from the next count so each output equals its decode of r_c.
  assign w_c_nxt     = r_c + 8'd1;
  assign w_s         = w_c_nxt[6:2];
  assign w_out_word  = w_c_nxt[7] ? r_frame[15:0] : r_frame[31:16];
  // Bit index 16-s modulo 16: s=1..15 -> 15..1, s=16 -> 0.
  assign w_idx       = 4'd0 - w_s[3:0];
  assign w_bit       = (w_s != 5'd0 && w_s <= 5'd16) ? w_out_word[w_idx] : 1'b0;
  assign ASCLK_o     = r_asclk;
  assign ASDATA_o    = r_asdata;
  assign ALRCLK_o    = r_alrclk;
  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      r_sclk      <= '0;
      r_lr        <= '0;
      r_sdat      <= '0;
      r_in_cnt    <= '0;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_pair      <= '0;
      r_frame     <= '0;
      r_c         <= '0;
      r_asclk     <= 1'b0;
      r_asdata    <= 1'b0;
      r_alrclk    <= 1'b0;
    end else begin
      r_sclk <= {r_sclk[1:0], ASCLK_i};
      r_lr   <= {r_lr[1:0], ALRCLK_i};
      r_sdat <= {r_sdat[0], ASDATA_i};
      if (w_lr_edge) begin
        r_in_cnt <= '0;
        r_shift  <= '0;
      end else if (w_sclk_rise && r_in_cnt != 5'd17) begin
        r_in_cnt <= r_in_cnt + 5'd1;
        if (r_in_cnt != 5'd0) r_shift <= w_word;
        if (r_in_cnt == 5'd16) begin
          if (r_lr[1]) r_left_hold <= w_word;
          else r_pair <= {r_left_hold, w_word};
        end
      end
      r_c <= w_c_nxt;
      if (r_c == 8'hFF) r_frame <= r_pair;
      r_asclk  <= w_c_nxt[1];
      r_alrclk <= w_c_nxt[7];
      r_asdata <= w_bit;
    end
  end
endmodule

// File: tb/tb_n64_audio_i2s_bridge.sv
// tb_n64_audio_i2s_bridge: directed bench for the N64 audio to I2S bridge
module tb_n64_audio_i2s_bridge;
  logic AMCLK_i = 1'b0, nARST = 1'b0, ASCLK_i = 1'b0, ASDATA_i = 1'b0, ALRCLK_i = 1'b0;
  logic ASCLK_o, ASDATA_o, ALRCLK_o;
  int checks = 0, errors = 0;
  always #20 AMCLK_i = ~AMCLK_i;
  n64_audio_i2s_bridge dut (
    .AMCLK_i(AMCLK_i), .nARST(nARST), .ASCLK_i(ASCLK_i), .ASDATA_i(ASDATA_i),
    .ALRCLK_i(ALRCLK_i), .ASCLK_o(ASCLK_o), .ASDATA_o(ASDATA_o), .ALRCLK_o(ALRCLK_o)
  );
  // One word: delay-slot bit then nbits data bits MSB first, 500 ns bit period.
  task automatic send_bits(input logic lr, input logic [15:0] w, input int nbits);
    ASCLK_i = 1'b0; ALRCLK_i = lr; ASDATA_i = 1'b0; #250; ASCLK_i = 1'b1; #250;
    for (int i = 15; i > 15 - nbits; i--) begin
      ASCLK_i = 1'b0; ASDATA_i = w[i]; #250; ASCLK_i = 1'b1; #250;
    end
  endtask
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    send_bits(1'b1, l, 16);
    send_bits(1'b0, r, 16);
  endtask
  task automatic measure(input bit use_lr, input int bound, output int per);
    logic p, cur;
    bit armed;
    int n;
    armed = 0; n = 0; per = 0;
    p = use_lr ? ALRCLK_o : ASCLK_o;
    for (int i = 0; i < bound; i++) begin
      @(negedge AMCLK_i);
      cur = use_lr ? ALRCLK_o : ASCLK_o;
      if (!p && cur) begin
        if (armed) begin per = n; break; end
        armed = 1; n = 0;
      end
      n++;
      p = cur;
    end
  endtask
  // Waits for ALRCLK_o falling (c=0), then samples all 256 cycles of one frame.
  task automatic capture(output logic [15:0] l, output logic [15:0] r, output bit ok);
    logic prev, d;
    bit found;
    int ph, slot, s;
    found = 0; l = '0; r = '0; d = 1'b0;
    @(negedge AMCLK_i);
    prev = ALRCLK_o;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge AMCLK_i);
      if (prev && !ALRCLK_o) found = 1;
      prev = ALRCLK_o;
    end
    ok = found;
    if (!found) return;
    for (int j = 0; j < 256; j++) begin
      if (j != 0) @(negedge AMCLK_i);
      ph = j % 4; slot = j / 4; s = slot % 32;
      if (ASCLK_o !== (ph >= 2)) ok = 0;
      if (ALRCLK_o !== (slot >= 32)) ok = 0;
      if (ph == 0) d = ASDATA_o;
      else if (ASDATA_o !== d) ok = 0;
      if (ph == 2) begin
        if (s >= 1 && s <= 16) begin
          if (slot < 32) l[16-s] = ASDATA_o;
          else r[16-s] = ASDATA_o;
        end else if (ASDATA_o !== 1'b0) ok = 0;
      end
    end
  endtask
  task automatic test_reset;
    logic [15:0] l, r;
    bit ok;
    int per;
    repeat (5) @(negedge AMCLK_i);
    checks++;
    if ({ASCLK_o, ALRCLK_o, ASDATA_o} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got %b want 000", {ASCLK_o, ALRCLK_o, ASDATA_o});
    end
    nARST = 1'b1;
    measure(1'b0, 20, per);
    checks++;
    if (per !== 4) begin errors++; $display("FAIL asclk_period got %0d want 4", per); end
    measure(1'b1, 600, per);
    checks++;
    if (per !== 256) begin errors++; $display("FAIL alrclk_period got %0d want 256", per); end
    capture(l, r, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_frame_format got 0 want 1"); end
    checks++;
    if (l !== 16'h0000) begin errors++; $display("FAIL reset_left got %h want 0000", l); end
    checks++;
    if (r !== 16'h0000) begin errors++; $display("FAIL reset_right got %h want 0000", r); end
  endtask
  task automatic test_single_pair;
    logic [15:0] l, r;
    bit ok;
    send_pair(16'h1234, 16'hABCD);
    capture(l, r, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_format got 0 want 1"); end
    checks++;
    if (l !== 16'h1234) begin errors++; $display("FAIL single_left got %h want 1234", l); end
    checks++;
    if (r !== 16'hABCD) begin errors++; $display("FAIL single_right got %h want abcd", r); end
  endtask
  task automatic test_extremes;
    logic [15:0] l, r;
    bit ok;
    send_pair(16'h8000, 16'h7FFF);
    capture(l, r, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL extremes_format got 0 want 1"); end
    checks++;
    if (l !== 16'h8000) begin errors++; $display("FAIL extremes_left got %h want 8000", l); end
    checks++;
    if (r !== 16'h7FFF) begin errors++; $display("FAIL extremes_right got %h want 7fff", r); end
  endtask
  task automatic test_ramp;
    logic [15:0] l, r, el, er;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      el = 16'(k);
      er = 16'd0 - el;
      send_pair(el, er);
      capture(l, r, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ramp%0d_format got 0 want 1", k); end
      checks++;
      if (l !== el) begin errors++; $display("FAIL ramp%0d_left got %h want %h", k, l, el); end
      checks++;
      if (r !== er) begin errors++; $display("FAIL ramp%0d_right got %h want %h", k, r, er); end
    end
  endtask
  task automatic test_aborted;
    logic [15:0] l, r;
    bit ok;
    send_bits(1'b1, 16'h5A5A, 8);
    send_bits(1'b0, 16'h2468, 16);
    capture(l, r, ok);
    checks++;
    if (l !== 16'h0003) begin errors++; $display("FAIL abort_left_kept got %h want 0003", l); end
    checks++;
    if (r !== 16'h2468) begin errors++; $display("FAIL abort_right_new got %h want 2468", r); end
    send_bits(1'b1, 16'h1111, 16);
    send_bits(1'b0, 16'h9999, 8);
    capture(l, r, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_format got 0 want 1"); end
    checks++;
    if (l !== 16'h0003) begin errors++; $display("FAIL abort2_left got %h want 0003", l); end
    checks++;
    if (r !== 16'h2468) begin errors++; $display("FAIL abort2_right got %h want 2468", r); end
  endtask
  task automatic test_reset_mid;
    logic [15:0] l, r;
    bit ok, hit;
    send_pair(16'hC3C3, 16'h3C3C);
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge AMCLK_i);
      hit = ASCLK_o && ALRCLK_o;
    end
    #5 nARST = 1'b0;
    #1;
    checks++;
    if (!hit || {ASCLK_o, ALRCLK_o, ASDATA_o} !== 3'b000) begin
      errors++; $display("FAIL midreset_outputs got %b (armed %0d) want 000", {ASCLK_o, ALRCLK_o, ASDATA_o}, hit);
    end
    repeat (3) @(negedge AMCLK_i);
    nARST = 1'b1;
    capture(l, r, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_format got 0 want 1"); end
    checks++;
    if ({l, r} !== 32'h0) begin errors++; $display("FAIL midreset_zero got %h want 00000000", {l, r}); end
    send_bits(1'b1, 16'h7777, 16);
    capture(l, r, ok);
    checks++;
    if ({l, r} !== 32'h0) begin errors++; $display("FAIL left_only_zero got %h want 00000000", {l, r}); end
    send_bits(1'b0, 16'h1357, 16);
    capture(l, r, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL recover_format got 0 want 1"); end
    checks++;
    if (l !== 16'h7777) begin errors++; $display("FAIL recover_left got %h want 7777", l); end
    checks++;
    if (r !== 16'h1357) begin errors++; $display("FAIL recover_right got %h want 1357", r); end
  endtask
  initial begin
    test_reset;
    test_single_pair;
    test_extremes;
    test_ramp;
    test_aborted;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/n64_audio_i2s_bridge.md
Name: n64_audio_i2s_bridge

Overview:
- Top-level audio processing unit of the N64 video/audio adapter.
- Deserialises the N64 AI serial audio stream (ASCLK/ASDATA/ALRCLK, 16-bit signed stereo) into parallel left/right samples.
- Re-serialises them as standard I2S, timed entirely from the local audio master clock AMCLK_i (256·fs), for the downstream DAC/HDMI audio path.
- The output is a sample-and-hold of the latest complete input stereo pair.

Parameters:
- None. Sample width is fixed at 16 bits; output frame is fixed at 64 bit-slots = 256 AMCLK cycles.

Ports:
- AMCLK_i  input  1  audio master clock; sole clock, all logic on rising edge
- nARST  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- ASCLK_i  input  1  N64 serial audio bit clock, asynchronous to AMCLK_i
- ASDATA_i  input  1  N64 serial audio data, MSB first, changes on ASCLK_i falling edge
- ALRCLK_i  input  1  N64 word select: 1 = left word, 0 = right word
- ASCLK_o  output  1  I2S bit clock = AMCLK_i/4
- ASDATA_o  output  1  I2S serial data
- ALRCLK_o  output  1  I2S word select = AMCLK_i/256; 0 = left, 1 = right

Behaviour:
- Reset: while nARST=0, all outputs are 0. All counters, shift registers, hold registers and frame registers are 0. Release takes effect on the next AMCLK_i edge.
- Input sync: ASCLK_i, ASDATA_i and ALRCLK_i each pass through 2 flops, plus a third flop for edge detection. ASCLK_i high and low phases must each be at least 3 AMCLK periods.
- Input bit counter in_cnt (0..17):
  - Any synced ALRCLK edge sets in_cnt=0 and clears the shift register. An unfinished word is discarded.
  - On each synced ASCLK rising edge with in_cnt<17: if in_cnt=0, skip (one-bit delay slot). Else shift the synced ASDATA into the LSB of the 16-bit shift register. Then increment in_cnt.
  - Once in_cnt=17, further ASCLK edges are ignored until the next ALRCLK edge.
- Word completion is the edge that moves in_cnt 16->17. The shifted word (including the current bit) goes to:
  - left_hold, if synced ALRCLK=1;
  - right_hold, if synced ALRCLK=0. In the same cycle, the pair {left_hold, new right word} is copied atomically into pair_reg.
- Output timing, counter c (8 bits, free-running, wraps 255->0):
  - ASCLK_o = c[1]
  - ALRCLK_o = c[7]
  - slot s = c[6:2], range 0..31 within each half
- Output data:
  - ASDATA_o = frame word bit (16-s) for s=1..16, where the frame word is left for c[7]=0 and right for c[7]=1.
  - ASDATA_o = 0 for s=0 and s=17..31.
  - I2S one-bit delay, MSB first, two's complement passed through unchanged.
- Output registering: all three outputs are registered and glitch-free. ASDATA_o and ALRCLK_o change only together with ASCLK_o falling (c[1:0]=0).
- Frame latch: when c=255, pair_reg is copied into frame_reg. A pair updated mid-frame appears in the next frame; no tearing.
- Rate handling:
  - Input slower than the output frame rate: the pair is repeated.
  - Input faster: intermediate pairs are dropped.
  - Only the latest complete pair is used.
- Latency: from the right word's 17th synced ASCLK rise to the first output bit is at most 3 + 256 + 8 AMCLK cycles.
- Reset mid-operation clears everything. The first frames output 0 until a full right word completes after a left word.

Test Plan:
- Reset: hold nARST=0 -> ASCLK_o, ALRCLK_o and ASDATA_o are 0. After release, ASCLK_o period = 4 AMCLK and ALRCLK_o period = 256 AMCLK. Before any input word completes, ASDATA_o stays 0.
- Single pair: AMCLK 40 ns; ASCLK 500 ns period. Left 0x1234 sent with ALRCLK=1, then right 0xABCD with ALRCLK=0. The next full output frame shows left slots 1..16 = 0x1234 and right slots 1..16 = 0xABCD; slots 0 and 17..31 are 0.
- Ramp: left increments from 0 and right decrements from 0 (0x0000/0x0000, then 0x0001/0xFFFF, ...). Output pairs follow the same sequence, with repeats only (no skips/tearing) when the output rate exceeds the input rate.
- Extremes: left 0x8000, right 0x7FFF -> output left MSB 1 then fifteen 0s; right MSB 0 then fifteen 1s.
- Aborted word: ALRCLK toggles after 8 data bits -> the partial word is discarded; hold registers and output keep the previous pair.
- Reset mid-frame: assert nARST while a non-zero pair is streaming -> outputs go 0 immediately (asynchronously). After release, the output is 0 until a new left+right pair completes.
